sys_bus_mem_slave: RTL and testbench

Single-port word-addressed memory model acting as the system-bus slave downstream of the cache controller. It accepts one read or one write transaction at a time on the five-channel ready/valid bus (readAddr, readData, writeAddr, writeData, writeResp). Reads are returned after a programmable latency. Writes are byte-masked, committed on acceptance, and acknowledged with a status word after a programmable latency. It serves as the backing store for cache refills and write-through traffic.

---
 rtl/sys_bus_mem_slave.sv | 132 +++++++++++++
 tb/tb_sys_bus_mem_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_mem_slave.sv
// Word-addressed memory slave on a five-channel ready/valid bus. It handles one
// read or one write at a time; responses follow programmable latencies.
module sys_bus_mem_slave #(
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] readAddr,
  input  logic        readAddr_valid,
  output logic        readAddr_ready,
  output logic [31:0] readData,
  output logic        readData_valid,
  input  logic        readData_ready,
  input  logic [31:0] writeAddr,
  input  logic        writeAddr_valid,
  output logic        writeAddr_ready,
  input  logic [31:0] writeData,
  input  logic [3:0]  writeStrb,
  input  logic        writeData_valid,
  output logic        writeData_ready,
  output logic        writeResp_valid,
  input  logic        writeResp_ready,
  output logic [31:0] writeResp_msg
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] R_WAIT = 3'd1;
  localparam logic [2:0] R_RESP = 3'd2;
  localparam logic [2:0] W_WAIT = 3'd3;
  localparam logic [2:0] W_RESP = 3'd4;

  logic [2:0]        state;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] rd_idx;
  logic              rd_err;
  logic [31:0]       mem [0:(1<<MEM_AW)-1];

  logic              rd_accept;
  logic              wr_accept;
  logic              rd_err_in;
  logic              wr_err_in;
  logic              mem_we;
  logic [MEM_AW-1:0] wr_idx_in;
  logic [3:0]        unused_addr_lsbs;

  // Byte offsets are dropped: every access is a whole aligned word.
  assign unused_addr_lsbs = {readAddr[1:0], writeAddr[1:0]};

  // NOTE: ready outputs are pure continuous assigns of state and readAddr_valid,
  // so no *_ready input can ever reach an output combinationally.
  assign readAddr_ready  = (state == IDLE);
  assign writeAddr_ready = (state == IDLE) && !readAddr_valid;
  assign writeData_ready = writeAddr_ready;

  assign rd_accept = (state == IDLE) && readAddr_valid;
  assign wr_accept = writeAddr_ready && writeAddr_valid && writeData_valid;
  assign rd_err_in = |readAddr[31:MEM_AW+2];
  assign wr_err_in = |writeAddr[31:MEM_AW+2];
  assign wr_idx_in = writeAddr[MEM_AW+1:2];
  assign mem_we    = wr_accept && !wr_err_in && !rst;

  // NOTE: the storage array has no reset; its contents power up undefined and
  // a write committed before a reset survives it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (writeStrb[b]) mem[wr_idx_in][8*b +: 8] <= writeData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      rd_idx          <= '0;
      rd_err          <= 1'b0;
      readData        <= 32'h0;
      readData_valid  <= 1'b0;
      writeResp_valid <= 1'b0;
      writeResp_msg   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_accept) begin
            rd_idx <= readAddr[MEM_AW+1:2];
            rd_err <= rd_err_in;
            cnt    <= 4'(RD_LAT);
            state  <= R_WAIT;
          end else if (wr_accept) begin
            writeResp_msg <= {31'h0, wr_err_in};
            cnt           <= 4'(WR_LAT);
            state         <= W_WAIT;
          end
        end
        R_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            readData       <= rd_err ? 32'h0 : mem[rd_idx];
            readData_valid <= 1'b1;
            state          <= R_RESP;
          end
        end
        R_RESP: begin
          if (readData_ready) begin
            readData_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        W_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            writeResp_valid <= 1'b1;
            state           <= W_RESP;
          end
        end
        W_RESP: begin
          if (writeResp_ready) begin
            writeResp_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_mem_slave.sv
// Directed bench for sys_bus_mem_slave: latency, byte masking, backpressure,
// read priority, out-of-range handling and reset during a read.
module tb_sys_bus_mem_slave;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;
  localparam int TMO    = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] readAddr = 32'h0;
  logic        readAddr_valid = 1'b0;
  logic        readAddr_ready;
  logic [31:0] readData;
  logic        readData_valid;
  logic        readData_ready = 1'b0;
  logic [31:0] writeAddr = 32'h0;
  logic        writeAddr_valid = 1'b0;
  logic        writeAddr_ready;
  logic [31:0] writeData = 32'h0;
  logic [3:0]  writeStrb = 4'h0;
  logic        writeData_valid = 1'b0;
  logic        writeData_ready;
  logic        writeResp_valid;
  logic        writeResp_ready = 1'b0;
  logic [31:0] writeResp_msg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  sys_bus_mem_slave #(.MEM_AW(10), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst(rst),
    .readAddr(readAddr), .readAddr_valid(readAddr_valid), .readAddr_ready(readAddr_ready),
    .readData(readData), .readData_valid(readData_valid), .readData_ready(readData_ready),
    .writeAddr(writeAddr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(writeAddr_ready),
    .writeData(writeData), .writeStrb(writeStrb), .writeData_valid(writeData_valid),
    .writeData_ready(writeData_ready), .writeResp_valid(writeResp_valid),
    .writeResp_ready(writeResp_ready), .writeResp_msg(writeResp_msg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one read; hold readData_ready low for 'hold' cycles after valid rises.
  task automatic do_read(input string tag, input logic [31:0] addr, input int hold,
                         output logic [31:0] data);
    int n;
    int t;
    readAddr = addr;
    readAddr_valid = 1'b1;
    readData_ready = 1'b0;
    #1;
    t = 0;
    while (!readAddr_ready && t < TMO) begin step(); t++; end
    chk({tag, "_acc"}, readAddr_ready, 1);
    n = cyc;
    step();
    readAddr_valid = 1'b0;
    t = 0;
    while (!readData_valid && t < TMO) begin step(); t++; end
    chk({tag, "_lat"}, cyc - n, RD_LAT + 2);
    data = readData;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_v"}, readData_valid, 1);
      chk({tag, "_hold_d"}, readData, data);
    end
    readData_ready = 1'b1;
    step();
    readData_ready = 1'b0;
    chk({tag, "_done_v"}, readData_valid, 0);
    chk({tag, "_idle"}, readAddr_ready, 1);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold, output logic [31:0] msg);
    int n;
    int t;
    writeAddr = addr;
    writeData = wdata;
    writeStrb = strb;
    writeAddr_valid = 1'b1;
    writeData_valid = 1'b1;
    writeResp_ready = 1'b0;
    #1;
    t = 0;
    while (!writeAddr_ready && t < TMO) begin step(); t++; end
    chk({tag, "_acc"}, writeData_ready, 1);
    n = cyc;
    step();
    writeAddr_valid = 1'b0;
    writeData_valid = 1'b0;
    t = 0;
    while (!writeResp_valid && t < TMO) begin step(); t++; end
    chk({tag, "_lat"}, cyc - n, WR_LAT + 2);
    msg = writeResp_msg;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_v"}, writeResp_valid, 1);
      chk({tag, "_hold_m"}, writeResp_msg, msg);
    end
    writeResp_ready = 1'b1;
    step();
    writeResp_ready = 1'b0;
    chk({tag, "_done_v"}, writeResp_valid, 0);
    chk({tag, "_idle"}, writeAddr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] m;
    int t;

    rst = 1'b1;
    dut.mem[0] = 32'hCAFEF00D;
    dut.mem[3] = 32'h11223344;
    dut.mem[5] = 32'hDEADBEEF;
    dut.mem[6] = 32'h0BADF00D;
    dut.mem[8] = 32'h01020304;
    dut.mem[9] = 32'h99999999;
    repeat (2) step();
    rst = 1'b0;
    step();

    chk("rst_rrdy", readAddr_ready, 1);
    chk("rst_wrdy", writeAddr_ready, 1);
    chk("rst_rvalid", readData_valid, 0);
    chk("rst_bvalid", writeResp_valid, 0);
    chk("rst_rdata", readData, 32'h0);
    chk("rst_msg", writeResp_msg, 32'h0);

    // Latency and data of a plain read.
    do_read("rd5", 32'h14, 0, d);
    chk("rd5_data", d, 32'hDEADBEEF);

    // Byte-masked write then read-back.
    do_write("wr3", 32'hC, 32'hAABBCCDD, 4'b0101, 0, m);
    chk("wr3_msg", m, 32'h0);
    do_read("rb3", 32'hC, 0, d);
    chk("rb3_data", d, 32'h11BB33DD);

    // Backpressure on both response channels.
    do_read("bp_rd", 32'h18, 5, d);
    chk("bp_rd_data", d, 32'h0BADF00D);
    do_write("bp_wr", 32'h18, 32'h12345678, 4'b1000, 5, m);
    chk("bp_wr_msg", m, 32'h0);
    do_read("bp_rb", 32'h18, 0, d);
    chk("bp_rb_data", d, 32'h12ADF00D);

    // A lone address or data valid must never be accepted.
    writeAddr = 32'h24;
    writeData = 32'h0;
    writeStrb = 4'hF;
    writeAddr_valid = 1'b1;
    repeat (2) step();
    writeAddr_valid = 1'b0;
    writeData_valid = 1'b1;
    repeat (2) step();
    writeData_valid = 1'b0;
    chk("lone_idle", writeAddr_ready, 1);
    chk("lone_noresp", writeResp_valid, 0);
    do_read("lone_rb", 32'h24, 0, d);
    chk("lone_rb_data", d, 32'h99999999);

    // Simultaneous read and write: read wins, write follows.
    readAddr = 32'h20;
    readAddr_valid = 1'b1;
    writeAddr = 32'h20;
    writeData = 32'h55667788;
    writeStrb = 4'hF;
    writeAddr_valid = 1'b1;
    writeData_valid = 1'b1;
    #1;
    chk("sim_rrdy", readAddr_ready, 1);
    chk("sim_awrdy", writeAddr_ready, 0);
    chk("sim_wdrdy", writeData_ready, 0);
    step();
    readAddr_valid = 1'b0;
    #1;
    chk("sim_busy", writeAddr_ready, 0);
    t = 0;
    while (!readData_valid && t < TMO) begin step(); t++; end
    chk("sim_rdata", readData, 32'h01020304);
    chk("sim_busy2", writeData_ready, 0);
    readData_ready = 1'b1;
    step();
    readData_ready = 1'b0;
    chk("sim_wr_rdy", writeAddr_ready, 1);
    step();
    writeAddr_valid = 1'b0;
    writeData_valid = 1'b0;
    t = 0;
    while (!writeResp_valid && t < TMO) begin step(); t++; end
    chk("sim_bvalid", writeResp_valid, 1);
    chk("sim_msg", writeResp_msg, 32'h0);
    writeResp_ready = 1'b1;
    step();
    writeResp_ready = 1'b0;
    do_read("sim_rb", 32'h20, 0, d);
    chk("sim_rb_data", d, 32'h55667788);

    // Out-of-range write aliases onto word 0 index but must not touch it.
    do_write("oor_wr", 32'h0000_1000, 32'hFFFFFFFF, 4'hF, 0, m);
    chk("oor_msg", m, 32'h1);
    do_read("oor_rd", 32'h0000_1000, 0, d);
    chk("oor_rdata", d, 32'h0);
    do_read("oor_w0", 32'h0, 0, d);
    chk("oor_w0_data", d, 32'hCAFEF00D);

    // Put non-zero values on the registered outputs, then reset during R_WAIT.
    do_write("pre_rst", 32'h0000_2000, 32'h0, 4'h0, 0, m);
    do_read("pre_rst_rd", 32'h14, 0, d);
    readAddr = 32'h14;
    readAddr_valid = 1'b1;
    step();
    readAddr_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rvalid", readData_valid, 0);
    chk("mid_bvalid", writeResp_valid, 0);
    chk("mid_msg", writeResp_msg, 32'h0);
    chk("mid_rdata", readData, 32'h0);
    chk("mid_rrdy", readAddr_ready, 1);
    step();
    rst = 1'b0;
    step();
    chk("post_rvalid", readData_valid, 0);
    do_read("post_rd", 32'h14, 0, d);
    chk("post_rd_data", d, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
